// File: rtl/uart_fifo_ctrl.sv
// UART with parameterised frame format, runtime baud divisor and FWFT TX/RX FIFOs.
// Reports per-word frame/parity flags, break pulses and a sticky RX overrun.

module uart_fifo_ctrl_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    push,
  input  logic [Width-1:0]        wdata,
  input  logic                    pop,
  output logic [Width-1:0]        rdata,
  output logic [$clog2(Depth):0]  level,
  output logic                    empty,
  output logic                    full
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LvlW'(Depth));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LvlW'(1);
        2'b01:   level <= level - LvlW'(1);
        default: ;
      endcase
    end
  end
endmodule

module uart_fifo_ctrl #(
  parameter int unsigned DataBits       = 8,
  parameter int unsigned StopBits       = 1,
  parameter string       ParityBit      = "none",
  parameter int unsigned OversampleRate = 16,
  parameter int unsigned DivWidth       = 16,
  parameter int unsigned TxFifoDepth    = 16,
  parameter int unsigned RxFifoDepth    = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [DivWidth-1:0]           baud_div_i,
  output logic                          uart_txd_o,
  input  logic                          uart_rxd_i,
  input  logic [DataBits-1:0]           tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_idle_o,
  output logic [$clog2(TxFifoDepth):0]  tx_level_o,
  output logic [DataBits-1:0]           rx_data_o,
  output logic                          rx_frame_error_o,
  output logic                          rx_parity_error_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(RxFifoDepth):0]  rx_level_o,
  output logic                          rx_break_o,
  output logic                          rx_overrun_o,
  input  logic                          rx_overrun_clr_i
);
  localparam int unsigned OsW  = $clog2(OversampleRate + 1);
  localparam int unsigned BitW = $clog2(DataBits);
  localparam int unsigned Half = OversampleRate / 2;
  localparam bit HasParity = (ParityBit != "none");
  localparam bit ParOdd    = (ParityBit == "odd");
  localparam bit ParMark   = (ParityBit == "mark");
  localparam bit ParSpace  = (ParityBit == "space");

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  function automatic logic par_of(input logic [DataBits-1:0] d);
    logic p;
    if (ParMark)       p = 1'b1;
    else if (ParSpace) p = 1'b0;
    else if (ParOdd)   p = ~^d;
    else               p = ^d;
    return p;
  endfunction

  // Oversample tick; a new divisor takes effect at the next reload.
  logic [DivWidth-1:0] div_eff;
  logic [DivWidth-1:0] tick_cnt;
  logic                tick;

  assign div_eff = (baud_div_i == '0) ? DivWidth'(1) : baud_div_i;
  assign tick    = (tick_cnt == '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   tick_cnt <= '0;
    else if (tick) tick_cnt <= div_eff - DivWidth'(1);
    else           tick_cnt <= tick_cnt - DivWidth'(1);
  end

  logic [DataBits-1:0] tx_head;
  logic                tx_empty;
  logic                tx_full;
  logic                tx_load;

  uart_fifo_ctrl_fifo #(.Width(DataBits), .Depth(TxFifoDepth)) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (tx_valid_i),
    .wdata   (tx_data_i),
    .pop     (tx_load),
    .rdata   (tx_head),
    .level   (tx_level_o),
    .empty   (tx_empty),
    .full    (tx_full)
  );

  tx_state_e           tx_state, tx_state_n;
  logic [DataBits-1:0] tx_shift, tx_shift_n, tx_shift_dn;
  logic                tx_par, tx_par_n;
  logic [OsW-1:0]      tx_os, tx_os_n;
  logic [BitW-1:0]     tx_bit, tx_bit_n;
  logic                tx_stop, tx_stop_n;
  logic                txd_q, txd_n;
  logic                tx_bit_end;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx_os    <= tx_os_n;
      tx_bit   <= tx_bit_n;
      tx_stop  <= tx_stop_n;
      txd_q    <= txd_n;
    end
  end

  // Line value for the next bit is registered at each bit boundary.
  always_comb begin
    tx_state_n  = tx_state;
    tx_shift_n  = tx_shift;
    tx_par_n    = tx_par;
    tx_os_n     = tx_os;
    tx_bit_n    = tx_bit;
    tx_stop_n   = tx_stop;
    txd_n       = txd_q;
    tx_load     = 1'b0;
    tx_shift_dn = tx_shift >> 1;
    tx_bit_end  = tick && (tx_os == OsW'(OversampleRate - 1));
    if (tx_state != TX_IDLE && tick) tx_os_n = tx_bit_end ? '0 : tx_os + OsW'(1);
    case (tx_state)
      TX_IDLE:  tx_load = tick && !tx_empty;
      TX_START: if (tx_bit_end) begin
        tx_state_n = TX_DATA;
        txd_n      = tx_shift[0];
        tx_bit_n   = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        if (tx_bit == BitW'(DataBits - 1)) begin
          if (HasParity) begin
            tx_state_n = TX_PARITY;
            txd_n      = tx_par;
          end else begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
            tx_stop_n  = 1'b0;
          end
        end else begin
          tx_shift_n = tx_shift_dn;
          txd_n      = tx_shift_dn[0];
          tx_bit_n   = tx_bit + BitW'(1);
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_n = TX_STOP;
        txd_n      = 1'b1;
        tx_stop_n  = 1'b0;
      end
      TX_STOP: if (tx_bit_end) begin
        if (tx_stop == 1'(StopBits - 1)) begin
          if (!tx_empty) tx_load = 1'b1;
          else begin
            tx_state_n = TX_IDLE;
            txd_n      = 1'b1;
          end
        end else begin
          tx_stop_n = 1'b1;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        txd_n      = 1'b1;
      end
    endcase
    if (tx_load) begin
      tx_state_n = TX_START;
      tx_shift_n = tx_head;
      tx_par_n   = par_of(tx_head);
      tx_os_n    = '0;
      txd_n      = 1'b0;
    end
  end

  assign uart_txd_o = txd_q;
  assign tx_ready_o = !tx_full;
  assign tx_idle_o  = tx_empty && (tx_state == TX_IDLE);

  logic [1:0] rx_sync;
  logic       rxs;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rx_sync <= 2'b11;
    else         rx_sync <= {rx_sync[0], uart_rxd_i};
  end
  assign rxs = rx_sync[1];

  rx_state_e           rx_state, rx_state_n;
  logic [DataBits-1:0] rx_shift, rx_shift_n;
  logic [OsW-1:0]      rx_os, rx_os_n, rx_os_inc;
  logic [BitW-1:0]     rx_bit, rx_bit_n;
  logic                rx_par_err, rx_par_err_n;
  logic                rx_parbit, rx_parbit_n;
  logic                rx_break_q, rx_break_n;
  logic                rx_push, rx_frame_err, rx_sample;
  logic                rx_empty, rx_full, overrun_q;
  logic [DataBits+1:0] rx_word;

  uart_fifo_ctrl_fifo #(.Width(DataBits + 2), .Depth(RxFifoDepth)) u_rx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (rx_push),
    .wdata   ({rx_frame_err, rx_par_err, rx_shift}),
    .pop     (rx_ready_i),
    .rdata   (rx_word),
    .level   (rx_level_o),
    .empty   (rx_empty),
    .full    (rx_full)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_state   <= RX_IDLE;
      rx_shift   <= '0;
      rx_os      <= '0;
      rx_bit     <= '0;
      rx_par_err <= 1'b0;
      rx_parbit  <= 1'b0;
      rx_break_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_shift   <= rx_shift_n;
      rx_os      <= rx_os_n;
      rx_bit     <= rx_bit_n;
      rx_par_err <= rx_par_err_n;
      rx_parbit  <= rx_parbit_n;
      rx_break_q <= rx_break_n;
      if (rx_push && rx_full)   overrun_q <= 1'b1;
      else if (rx_overrun_clr_i) overrun_q <= 1'b0;
    end
  end

  // Detection tick is tick 0; bits are sampled OversampleRate ticks apart from mid-start.
  always_comb begin
    rx_state_n   = rx_state;
    rx_shift_n   = rx_shift;
    rx_os_n      = rx_os;
    rx_bit_n     = rx_bit;
    rx_par_err_n = rx_par_err;
    rx_parbit_n  = rx_parbit;
    rx_break_n   = 1'b0;
    rx_push      = 1'b0;
    rx_frame_err = 1'b0;
    rx_os_inc    = rx_os + OsW'(1);
    rx_sample    = tick && (rx_os_inc == OsW'(OversampleRate));
    if (tick && (rx_state inside {RX_DATA, RX_PARITY, RX_STOP}))
      rx_os_n = rx_sample ? '0 : rx_os_inc;
    case (rx_state)
      RX_IDLE: if (tick && !rxs) begin
        rx_state_n = RX_START;
        rx_os_n    = '0;
      end
      RX_START: if (tick) begin
        if (rx_os_inc == OsW'(Half - 1)) begin
          rx_os_n = '0;
          if (rxs) rx_state_n = RX_IDLE;
          else begin
            rx_state_n = RX_DATA;
            rx_bit_n   = '0;
          end
        end else begin
          rx_os_n = rx_os_inc;
        end
      end
      RX_DATA: if (rx_sample) begin
        rx_shift_n = {rxs, rx_shift[DataBits-1:1]};
        if (rx_bit == BitW'(DataBits - 1)) rx_state_n = HasParity ? RX_PARITY : RX_STOP;
        else                               rx_bit_n   = rx_bit + BitW'(1);
      end
      RX_PARITY: if (rx_sample) begin
        rx_parbit_n  = rxs;
        rx_par_err_n = (rxs != par_of(rx_shift));
        rx_state_n   = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        if (rxs) begin
          rx_push    = 1'b1;
          rx_state_n = RX_IDLE;
        end else if (rx_shift == '0 && !rx_parbit) begin
          rx_break_n = 1'b1;
          rx_state_n = RX_WAIT_HIGH;
        end else begin
          rx_push      = 1'b1;
          rx_frame_err = 1'b1;
          rx_state_n   = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (tick && rxs) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign rx_data_o         = rx_word[DataBits-1:0];
  assign rx_parity_error_o = rx_word[DataBits];
  assign rx_frame_error_o  = rx_word[DataBits+1];
  assign rx_valid_o        = !rx_empty;
  assign rx_break_o        = rx_break_q;
  assign rx_overrun_o      = overrun_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: 8 data bits, even parity, 1 stop, OS=16, 4-deep FIFOs.

module tb_uart_fifo_ctrl;
  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] baud_div;
  logic        txd, rxd, rxd_drv, loop;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_idle;
  logic [2:0]  tx_level, rx_level;
  logic [7:0]  rx_data;
  logic        rx_fe, rx_pe, rx_valid, rx_ready, rx_break, rx_overrun;
  logic        clr_pulse, clr_hold, rx_clr;
  int          vectors = 0;
  int          miscompares = 0;
  int          bitc = 64;
  int          brk_cnt = 0;
  int          ovr_seen = 0;
  int          ovr_base = 0;

  assign rxd    = loop ? txd : rxd_drv;
  assign rx_clr = clr_pulse | (clr_hold & (ovr_seen == ovr_base));

  uart_fifo_ctrl #(
    .DataBits(8), .StopBits(1), .ParityBit("even"), .OversampleRate(16),
    .DivWidth(16), .TxFifoDepth(4), .RxFifoDepth(4)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .baud_div_i        (baud_div),
    .uart_txd_o        (txd),
    .uart_rxd_i        (rxd),
    .tx_data_i         (tx_data),
    .tx_valid_i        (tx_valid),
    .tx_ready_o        (tx_ready),
    .tx_idle_o         (tx_idle),
    .tx_level_o        (tx_level),
    .rx_data_o         (rx_data),
    .rx_frame_error_o  (rx_fe),
    .rx_parity_error_o (rx_pe),
    .rx_valid_o        (rx_valid),
    .rx_ready_i        (rx_ready),
    .rx_level_o        (rx_level),
    .rx_break_o        (rx_break),
    .rx_overrun_o      (rx_overrun),
    .rx_overrun_clr_i  (rx_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_break) brk_cnt++;
    if (rx_clr && rx_overrun) ovr_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_fall(input int limit, output int n);
    n = 0;
    while (txd !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", txd, 0);
  endtask

  // Counts how many samples of one bit period carry the expected line level.
  task automatic tx_bit(input logic exp, input string tag);
    int n;
    n = 0;
    for (int i = 0; i < bitc; i++) begin
      if (txd === exp) n++;
      @(negedge clk);
    end
    check(tag, n, bitc);
  endtask

  task automatic tx_frame(input logic [7:0] d, input string tag);
    tx_bit(1'b0, {tag, "_start"});
    for (int i = 0; i < 8; i++) tx_bit(d[i], $sformatf("%s_d%0d", tag, i));
    tx_bit(^d, {tag, "_par"});
    tx_bit(1'b1, {tag, "_stop"});
    check({tag, "_idle"}, tx_idle, 1);
  endtask

  task automatic rx_bit(input logic b);
    rxd_drv = b;
    repeat (bitc) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
    rx_bit(par);
    rx_bit(stop);
    rx_bit(1'b1);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, d);
    check({tag, "_fe"}, rx_fe, fe);
    check({tag, "_pe"}, rx_pe, pe);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] w [5];
    reset_i = 1'b1; baud_div = 16'd4; rxd_drv = 1'b1; loop = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clr_pulse = 1'b0; clr_hold = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_idle", tx_idle, 1);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_flags", {rx_fe, rx_pe, rx_break, rx_overrun}, 0);
    check("rst_rx_level", rx_level, 0);
    reset_i = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame 0xA5: exact bit timing at 64 clocks per bit.
    push_word(8'hA5);
    check("a5_level", tx_level, 1);
    check("a5_busy", tx_idle, 0);
    wait_fall(20, n);
    check("a5_latency_ok", n <= 6, 1);
    tx_frame(8'hA5, "a5");

    // Loopback, divisor 3: three back-to-back frames with no gap.
    baud_div = 16'd3; bitc = 48; loop = 1'b1;
    repeat (10) @(negedge clk);
    push_word(8'h00); push_word(8'hFF); push_word(8'h5A);
    wait_fall(20, n);
    n = 0;
    while (!tx_idle && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("lb_burst_clocks", n, 3 * 11 * 48);
    repeat (100) @(negedge clk);
    check("lb_rx_level", rx_level, 3);
    pop_check("lb0", 8'h00, 0, 0);
    pop_check("lb1", 8'hFF, 0, 0);
    pop_check("lb2", 8'h5A, 0, 0);
    loop = 1'b0;

    // Overrun: five frames into a 4-deep RX FIFO.
    baud_div = 16'd4; bitc = 64;
    repeat (10) @(negedge clk);
    w = '{8'h11, 8'h23, 8'h47, 8'h8F, 8'h55};
    for (int i = 0; i < 4; i++) send_frame(w[i], ^w[i], 1'b1);
    check("ovr_level4", rx_level, 4);
    check("ovr_not_yet", rx_overrun, 0);
    send_frame(w[4], ^w[4], 1'b1);
    check("ovr_level_full", rx_level, 4);
    check("ovr_set", rx_overrun, 1);
    check("ovr_head_intact", rx_data, 8'h11);
    clr_pulse = 1'b1;
    @(negedge clk);
    clr_pulse = 1'b0;
    check("ovr_cleared", rx_overrun, 0);
    ovr_base = ovr_seen;
    clr_hold = 1'b1;
    send_frame(8'h66, ^8'h66, 1'b1);
    clr_hold = 1'b0;
    check("ovr_set_wins_seen", ovr_seen - ovr_base, 1);
    check("ovr_set_wins_held", rx_overrun, 1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovr_w%0d", i), w[i], 0, 0);
    check("ovr_drained", rx_valid, 0);

    // Stop bit low on a non-zero word.
    send_frame(8'h3C, 1'b0, 1'b0);
    check("fe_level", rx_level, 1);
    pop_check("fe", 8'h3C, 1, 0);

    // Break: line low for two frame times.
    n = brk_cnt;
    rxd_drv = 1'b0;
    repeat (22 * bitc) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2 * bitc) @(negedge clk);
    check("brk_pulses", brk_cnt - n, 1);
    check("brk_level", rx_level, 0);
    send_frame(8'hA7, ^8'hA7, 1'b1);
    pop_check("post_brk", 8'hA7, 0, 0);

    // Start glitch of 5 ticks, then a wrong parity bit.
    rxd_drv = 1'b0;
    repeat (5 * 4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (3 * bitc) @(negedge clk);
    check("glitch_level", rx_level, 0);
    send_frame(8'h01, 1'b0, 1'b1);
    pop_check("pe", 8'h01, 0, 1);

    // Reset during TX bit 3 with the FIFO full behind it.
    push_word(8'hC3);
    wait_fall(20, n);
    push_word(8'h12); push_word(8'h34); push_word(8'h56); push_word(8'h78);
    check("full_level", tx_level, 4);
    check("full_ready", tx_ready, 0);
    push_word(8'h9A);
    check("full_no_push", tx_level, 4);
    repeat (288 - 5) @(negedge clk);
    check("mid_bit3", txd, 0);
    #2 reset_i = 1'b1;
    #1;
    check("rst_mid_txd", txd, 1);
    check("rst_mid_level", tx_level, 0);
    check("rst_mid_ready", tx_ready, 1);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    push_word(8'h96);
    wait_fall(20, n);
    tx_frame(8'h96, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
